// File: rtl/comanda_numarator_if.sv
// Button/switch inputs and counter-control outputs between the panel and comanda_numarator.
`timescale 1ns/1ps
interface comanda_numarator_if #(
  parameter int WIDTH = 5
);
  logic             btn_start;
  logic             btn_stop;
  logic             btn_dir;
  logic             btn_load;
  logic [WIDTH-1:0] sw_val;
  logic             load;
  logic             en;
  logic             UpDown;
  logic [WIDTH-1:0] in_val;
  logic             running;

  modport master (
    output btn_start, btn_stop, btn_dir, btn_load, sw_val,
    input  load, en, UpDown, in_val, running
  );

  modport slave (
    input  btn_start, btn_stop, btn_dir, btn_load, sw_val,
    output load, en, UpDown, in_val, running
  );
endinterface

// File: rtl/comanda_numarator.sv
// Control stage for the 5-bit up/down counter: button sync + edge detect,
// run/idle/load sequencing and an en prescaler.
//
// state | meaning
// IDLE  | counter halted, waiting for start or load
// RUN   | prescaler running, en pulses once per DIV cycles
// LOAD  | single cycle presenting load=1 and the captured preset
`timescale 1ns/1ps
module comanda_numarator #(
  parameter int WIDTH = 5,
  parameter int DIV   = 4
) (
  input  logic ck,
  input  logic reset,
  comanda_numarator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LOAD = 2'b10
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

  // bit order everywhere: {load, dir, stop, start}
  logic [3:0] btn_raw;
  logic [3:0] s1, s2, s2_d;
  logic [3:0] cmd;

  state_t           state, state_nx;
  logic [7:0]       presc, presc_nx;
  logic [2:0]       pend, pend_nx;
  logic             load_nx, en_nx, updown_nx;
  logic [WIDTH-1:0] in_val_nx;
  logic             eff_start, eff_stop, eff_load;

  assign btn_raw = {bus.btn_load, bus.btn_dir, bus.btn_stop, bus.btn_start};
  assign cmd     = s2 & ~s2_d;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  // Commands seen during the LOAD cycle are replayed once IDLE is reached.
  assign eff_start = cmd[0] | pend[0];
  assign eff_stop  = cmd[1] | pend[1];
  assign eff_load  = cmd[3] | pend[2];

  always_comb begin
    state_nx  = IDLE;
    presc_nx  = '0;
    pend_nx   = '0;
    load_nx   = 1'b0;
    en_nx     = 1'b0;
    in_val_nx = bus.in_val;
    updown_nx = bus.UpDown ^ cmd[2];
    case (state)
      RUN: begin
        if (eff_load) begin
          state_nx  = LOAD;
          load_nx   = 1'b1;
          in_val_nx = bus.sw_val;
        end else if (!eff_stop) begin
          state_nx = RUN;
          en_nx    = (presc == PRESC_LAST);
          presc_nx = (presc == PRESC_LAST) ? 8'd0 : presc + 8'd1;
        end
      end
      LOAD: begin
        state_nx = IDLE;
        pend_nx  = {cmd[3], cmd[1], cmd[0]};
      end
      default: begin
        if (eff_load) begin
          state_nx  = LOAD;
          load_nx   = 1'b1;
          in_val_nx = bus.sw_val;
        end else if (eff_start) begin
          state_nx = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      presc       <= '0;
      pend        <= '0;
      bus.load    <= 1'b0;
      bus.en      <= 1'b0;
      bus.UpDown  <= 1'b1;
      bus.in_val  <= '0;
      bus.running <= 1'b0;
    end else begin
      state       <= state_nx;
      presc       <= presc_nx;
      pend        <= pend_nx;
      bus.load    <= load_nx;
      bus.en      <= en_nx;
      bus.UpDown  <= updown_nx;
      bus.in_val  <= in_val_nx;
      bus.running <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_comanda_numarator.sv
// Scoreboard bench for comanda_numarator: directed button sequences followed by
// random button activity, checked cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_comanda_numarator;

  localparam int WIDTH = 5;
  localparam int DIV   = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOAD = 2;

  typedef struct packed {
    logic             load;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] inval;
    logic             run;
  } exp_t;

  logic ck = 1'b0;
  logic reset = 1'b0;
  comanda_numarator_if #(.WIDTH(WIDTH)) bus ();

  comanda_numarator #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #2 ck = ~ck;

  int errors = 0;
  int checks = 0;

  exp_t             exp_q[$];
  logic [3:0]       hist[$];
  logic [WIDTH-1:0] sw_cur = '0;
  int               m_mode = M_IDLE;
  int               m_n = 0;
  int               m_entry = 0;
  logic [3:0]       m_def = '0;
  logic             m_up = 1'b1;
  logic [WIDTH-1:0] m_inval = '0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  // Expected outputs after the coming rising edge, from button levels sampled at
  // that edge. A press becomes a command two edges after it is first sampled.
  task automatic model_edge(input logic [3:0] b, input logic [WIDTH-1:0] sw, input logic r);
    exp_t e;
    logic [3:0] c2, c3, cmd;
    logic st, sp, ld;
    m_n++;
    e = '0;
    if (!r) begin
      m_mode  = M_IDLE;
      m_up    = 1'b1;
      m_inval = '0;
      m_def   = '0;
      hist.delete();
      e.up = 1'b1;
      exp_q.push_back(e);
      return;
    end
    hist.push_front(b);
    if (hist.size() > 4) void'(hist.pop_back());
    c2  = (hist.size() > 2) ? hist[2] : 4'b0;
    c3  = (hist.size() > 3) ? hist[3] : 4'b0;
    cmd = c2 & ~c3;
    if (m_mode == M_LOAD) begin
      m_def  = cmd & 4'b1011;
      m_mode = M_IDLE;
    end else begin
      st = cmd[0] | m_def[0];
      sp = cmd[1] | m_def[1];
      ld = cmd[3] | m_def[3];
      m_def = '0;
      if (ld) begin
        m_mode  = M_LOAD;
        m_inval = sw;
        e.load  = 1'b1;
      end else if (m_mode == M_RUN) begin
        if (sp) m_mode = M_IDLE;
        else e.en = ((m_n - m_entry) % DIV == 0);
      end else if (st) begin
        m_mode  = M_RUN;
        m_entry = m_n;
      end
    end
    if (cmd[2]) m_up = ~m_up;
    e.up    = m_up;
    e.inval = m_inval;
    e.run   = (m_mode == M_RUN);
    exp_q.push_back(e);
  endtask

  // b = {load, dir, stop, start}; r = reset level for the coming edge
  task automatic step(input logic [3:0] b, input logic r);
    @(negedge ck);
    bus.btn_start = b[0];
    bus.btn_stop  = b[1];
    bus.btn_dir   = b[2];
    bus.btn_load  = b[3];
    bus.sw_val    = sw_cur;
    if (!r && reset) begin
      reset = 1'b0;
      #1;
      chk("rst_now_load", int'(bus.load), 0);
      chk("rst_now_en", int'(bus.en), 0);
      chk("rst_now_updown", int'(bus.UpDown), 1);
      chk("rst_now_inval", int'(bus.in_val), 0);
      chk("rst_now_running", int'(bus.running), 0);
    end else begin
      reset = r;
    end
    model_edge(b, sw_cur, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge ck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("load", int'(bus.load), int'(e.load));
        chk("en", int'(bus.en), int'(e.en));
        chk("updown", int'(bus.UpDown), int'(e.up));
        chk("in_val", int'(bus.in_val), int'(e.inval));
        chk("running", int'(bus.running), int'(e.run));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] lv;
    int rst_cnt;
    bus.btn_start = 1'b0;
    bus.btn_stop  = 1'b0;
    bus.btn_dir   = 1'b0;
    bus.btn_load  = 1'b0;
    bus.sw_val    = '0;

    // reset held with buttons toggling
    for (int i = 0; i < 6; i++) begin
      sw_cur = WIDTH'(i + 3);
      step(4'(i * 5), 1'b0);
    end
    step(4'b0000, 1'b0);
    idle(3);

    // start, then watch three en pulses
    step(4'b0001, 1'b1);
    idle(15);

    // load while running
    sw_cur = 5'b10110;
    step(4'b1000, 1'b1);
    idle(4);

    // dir twice, then held for 20 cycles
    step(4'b0100, 1'b1);
    idle(4);
    step(4'b0100, 1'b1);
    idle(4);
    for (int i = 0; i < 20; i++) step(4'b0100, 1'b1);
    idle(4);

    // start/stop/load together from RUN
    sw_cur = 5'b01001;
    step(4'b0001, 1'b1);
    idle(7);
    step(4'b1011, 1'b1);
    idle(10);

    // stop command lands on the prescaler wrap, then restart
    step(4'b0001, 1'b1);
    idle(3);
    step(4'b0010, 1'b1);
    idle(8);
    step(4'b0001, 1'b1);
    idle(10);

    // start held through a mid-run reset release counts as a press
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b1);
    idle(4);

    // random button activity with occasional resets
    lv = '0;
    rst_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(5) == 0) lv[k] = ~lv[k];
      if ($urandom_range(19) == 0) sw_cur = WIDTH'($urandom);
      if (rst_cnt > 0) begin
        rst_cnt--;
        step(lv, 1'b0);
      end else if ($urandom_range(299) == 0) begin
        rst_cnt = $urandom_range(2);
        step(lv, 1'b0);
      end else begin
        step(lv, 1'b1);
      end
    end
    idle(3);

    @(posedge ck);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
